// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: resolves data-memory waits,
// taken branches, load-use hazards and jumps in fixed priority, with a memory-wait watchdog.
module pipeline_ctrl #(
    parameter int REG_W       = 4,
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jmp,
    input  logic [PC_W-1:0]  id_pc_jmp,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_branch,
    input  logic             ex_alu_zero,
    input  logic [PC_W-1:0]  ex_pc_branch,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_stall,
    output logic             if_jmp,
    output logic [PC_W-1:0]  if_pc_redirect,
    output logic             id_stall,
    output logic             id_flush,
    output logic             ex_bubble,
    output logic             mem_stall,
    output logic             mem_timeout,
    output logic [15:0]      stall_cycles
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]      stall_cycles_q, stall_cycles_d;
    logic             load_use;

    assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        if_stall       = 1'b0;
        if_jmp         = 1'b0;
        if_pc_redirect = '0;
        id_stall       = 1'b0;
        id_flush       = 1'b0;
        ex_bubble      = 1'b0;
        mem_stall      = 1'b0;
        mem_timeout    = 1'b0;

        if (reset) begin
            state_d    = RUN;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        if_stall   = 1'b1;
                        id_stall   = 1'b1;
                        mem_stall  = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = CNT_W'(1);
                    end else if (ex_branch && ex_alu_zero) begin
                        // The ID instruction is on the wrong path, so its hazards don't matter
                        if_jmp         = 1'b1;
                        if_pc_redirect = ex_pc_branch;
                        id_flush       = 1'b1;
                        ex_bubble      = 1'b1;
                    end else if (load_use) begin
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        ex_bubble = 1'b1;
                    end else if (id_jmp) begin
                        if_jmp         = 1'b1;
                        if_pc_redirect = id_pc_jmp;
                        id_flush       = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    mem_stall = 1'b1;
                    if (mem_ready) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                ERROR: begin
                    if_stall    = 1'b1;
                    id_stall    = 1'b1;
                    mem_stall   = 1'b1;
                    mem_timeout = 1'b1;
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end

        // Counter reads as zero during the reset cycle even if it held a value before
        stall_cycles_d = stall_cycles_q;
        stall_cycles   = stall_cycles_q;
        if (reset) begin
            stall_cycles_d = '0;
            stall_cycles   = '0;
        end else if (if_stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic, every cycle compared
// against a cycle-level model of the controller rules.
module tb_pipeline_ctrl;

    localparam int REG_W       = 4;
    localparam int PC_W        = 8;
    localparam int MEM_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rs, id_uses_rt, id_jmp;
    logic [PC_W-1:0]  id_pc_jmp, ex_pc_branch;
    logic             ex_reg_write, ex_mem_read, ex_branch, ex_alu_zero;
    logic             mem_req, mem_ready;
    logic             if_stall, if_jmp, id_stall, id_flush, ex_bubble, mem_stall, mem_timeout;
    logic [PC_W-1:0]  if_pc_redirect;
    logic [15:0]      stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: waiting on memory, consecutive unserved wait cycles, watchdog tripped, stalls seen
    bit m_wait;
    int m_cnt;
    bit m_err;
    int m_stalls;

    pipeline_ctrl #(.REG_W(REG_W), .PC_W(PC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_jmp(id_jmp), .id_pc_jmp(id_pc_jmp),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_alu_zero(ex_alu_zero), .ex_pc_branch(ex_pc_branch),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .if_stall(if_stall), .if_jmp(if_jmp), .if_pc_redirect(if_pc_redirect),
        .id_stall(id_stall), .id_flush(id_flush), .ex_bubble(ex_bubble),
        .mem_stall(mem_stall), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_idle();
        reset = 1'b0;
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jmp = 1'b0; id_pc_jmp = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch = 1'b0; ex_alu_zero = 1'b0;
        ex_pc_branch = '0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load_use(input logic [REG_W-1:0] rd);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
        id_rs = 4'd3; id_uses_rs = 1'b1;
    endtask

    // Check one cycle against the model at the falling edge, then advance the model
    task automatic step(input string tag);
        bit e_ifs, e_jmp, e_ids, e_flush, e_bub, e_ms, e_to, lu;
        logic [PC_W-1:0] e_pc;
        logic [30:0] e_v, o_v;
        @(negedge clk);
        {e_ifs, e_jmp, e_ids, e_flush, e_bub, e_ms, e_to} = '0;
        e_pc = '0;
        lu = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        if (reset) begin
        end else if (m_err) begin
            e_ifs = 1; e_ids = 1; e_ms = 1; e_to = 1;
        end else if (m_wait || (mem_req && !mem_ready)) begin
            e_ifs = 1; e_ids = 1; e_ms = 1;
        end else if (ex_branch && ex_alu_zero) begin
            e_jmp = 1; e_pc = ex_pc_branch; e_flush = 1; e_bub = 1;
        end else if (lu) begin
            e_ifs = 1; e_ids = 1; e_bub = 1;
        end else if (id_jmp) begin
            e_jmp = 1; e_pc = id_pc_jmp; e_flush = 1;
        end
        e_v = {e_ifs, e_jmp, e_pc, e_ids, e_flush, e_bub, e_ms, e_to,
               reset ? 16'd0 : 16'(m_stalls)};
        o_v = {if_stall, if_jmp, if_pc_redirect, id_stall, id_flush, ex_bubble, mem_stall,
               mem_timeout, stall_cycles};
        chk(tag, 32'(o_v), 32'(e_v));
        if (reset) begin
            m_wait = 0; m_cnt = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (e_ifs && m_stalls < 65535) m_stalls++;
            if (m_err) begin
            end else if (m_wait) begin
                if (mem_ready) m_wait = 0;
                else if (m_cnt == MEM_TIMEOUT) begin m_err = 1; m_wait = 0; end
                else m_cnt++;
            end else if (mem_req && !mem_ready) begin
                m_wait = 1; m_cnt = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        step("reset_pulse");
        reset = 1'b0;
    endtask

    initial begin
        m_wait = 0; m_cnt = 0; m_err = 0; m_stalls = 0;
        set_idle();

        // Reset cycle forces every output low even with active requests
        reset = 1'b1; mem_req = 1'b1; ex_branch = 1'b1; ex_alu_zero = 1'b1;
        ex_pc_branch = 8'h55; id_jmp = 1'b1; id_pc_jmp = 8'h66;
        #1;
        chk("reset_redirect", 32'(if_pc_redirect), 32'h0);
        chk("reset_jmp", 32'(if_jmp), 32'h0);
        step("reset_all");
        set_idle();
        step("idle_after_reset");

        // Load-use stall then no stall against r0
        set_load_use(4'd3);
        #1;
        chk("lu_stall", 32'({if_stall, id_stall, ex_bubble}), 32'h7);
        step("lu");
        set_idle();
        #1;
        chk("lu_count", 32'(stall_cycles), 32'd1);
        step("lu_after");
        set_load_use(4'd0);
        #1;
        chk("lu_r0", 32'(if_stall), 32'h0);
        step("lu_r0");

        // Branch beats jump; jump proceeds alone when branch not taken
        set_idle();
        ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_pc_branch = 8'h40;
        id_jmp = 1'b1; id_pc_jmp = 8'h80;
        set_load_use(4'd3);
        #1;
        chk("br_redirect", 32'(if_pc_redirect), 32'h40);
        step("br_taken");
        ex_alu_zero = 1'b0; ex_mem_read = 1'b0;
        #1;
        chk("jmp_redirect", 32'(if_pc_redirect), 32'h80);
        chk("jmp_bubble", 32'(ex_bubble), 32'h0);
        step("jmp");

        // Multi-cycle memory access with a pending jump
        do_reset();
        mem_req = 1'b1; id_jmp = 1'b1; id_pc_jmp = 8'h22;
        repeat (3) step("mem_wait");
        mem_ready = 1'b1;
        #1;
        chk("mem_last_stall", 32'(mem_stall), 32'h1);
        step("mem_ready");
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("mem_jmp_after", 32'({if_jmp, if_pc_redirect}), 32'h122);
        chk("mem_count", 32'(stall_cycles), 32'd4);
        step("mem_resume");

        // Watchdog trips on cycle 1+MEM_TIMEOUT+1 and is sticky until reset
        do_reset();
        mem_req = 1'b1;
        repeat (MEM_TIMEOUT) step("wd_wait");
        #1;
        chk("wd_not_yet", 32'(mem_timeout), 32'h0);
        step("wd_last_wait");
        chk("wd_tripped", 32'(mem_timeout), 32'h1);
        mem_req = 1'b0; mem_ready = 1'b1;
        repeat (3) step("wd_sticky");
        reset = 1'b1;
        step("wd_reset");
        reset = 1'b0;
        #1;
        chk("wd_cleared", 32'({mem_timeout, mem_stall}), 32'h0);
        step("wd_after");

        // Single-cycle access coinciding with a load-use hazard
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b1;
        set_load_use(4'd3);
        #1;
        chk("sc_no_memstall", 32'({mem_stall, if_stall, ex_bubble}), 32'h3);
        step("single_cycle");
        set_idle();
        step("single_cycle_after");

        // Randomized traffic with occasional resets to recover from the watchdog
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            id_rs        = REG_W'($urandom_range(0, 3));
            id_rt        = REG_W'($urandom_range(0, 3));
            ex_rd        = REG_W'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom);
            id_uses_rt   = 1'($urandom);
            id_jmp       = ($urandom_range(0, 3) == 0);
            id_pc_jmp    = PC_W'($urandom);
            ex_reg_write = 1'($urandom);
            ex_mem_read  = 1'($urandom);
            ex_branch    = ($urandom_range(0, 3) == 0);
            ex_alu_zero  = 1'($urandom);
            ex_pc_branch = PC_W'($urandom);
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ready    = ($urandom_range(0, 9) < 6);
            step("random");
        end

        // Stall counter saturates instead of wrapping
        do_reset();
        set_load_use(4'd3);
        repeat (70000) step("saturate");
        chk("sat_value", 32'(stall_cycles), 32'hFFFF);
        step("sat_hold");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the fetch stage's stall and redirect inputs, and the ID/EX stall, flush and bubble controls. It resolves load-use hazards, taken branches, jumps and multi-cycle data-memory waits with a fixed priority. It also keeps a memory-wait watchdog and a stall performance counter.

Parameters:
REG_W, 4, register index width
PC_W, 8, program counter width (matches fetch-stage PC)
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_rs  in  REG_W  ID-stage source register 1
id_rt  in  REG_W  ID-stage source register 2
id_uses_rs  in  1  ID instr reads rs
id_uses_rt  in  1  ID instr reads rt
id_jmp  in  1  ID instr is unconditional jump
id_pc_jmp  in  PC_W  jump target
ex_rd  in  REG_W  EX-stage destination register
ex_reg_write  in  1  EX instr writes rd
ex_mem_read  in  1  EX instr is a load
ex_branch  in  1  EX instr is a branch
ex_alu_zero  in  1  EX branch condition true
ex_pc_branch  in  PC_W  branch target
mem_req  in  1  MEM stage issuing data-memory access this cycle
mem_ready  in  1  data memory completes access this cycle
if_stall  out  1  hold PC
if_jmp  out  1  load PC from if_pc_redirect
if_pc_redirect  out  PC_W  redirect target
id_stall  out  1  hold IF/ID register
id_flush  out  1  clear IF/ID register to NOP
ex_bubble  out  1  insert NOP into ID/EX
mem_stall  out  1  hold EX/MEM and earlier; MEM/WB gets bubble
mem_timeout  out  1  sticky watchdog error
stall_cycles  out  16  saturating count of cycles with if_stall=1

Behaviour:
- Registered state is FSM {RUN, MEM_WAIT, ERROR}, a wait counter (width clog2(MEM_TIMEOUT+1)) and stall_cycles. All control outputs are combinational from state and inputs.
- Reset (sync): state=RUN, wait counter=0, stall_cycles=0, mem_timeout=0. During the reset cycle all outputs are 0 and if_pc_redirect=0.
- Invariants: if_jmp=1 implies if_stall=0. Outputs with no active condition are 0. if_pc_redirect=0 when if_jmp=0.
- Priority in RUN, highest first:
  1. Mem wait: mem_req & !mem_ready -> if_stall=id_stall=mem_stall=1, all others 0. Next state MEM_WAIT, counter=1.
  2. Taken branch: ex_branch & ex_alu_zero -> if_jmp=1, if_pc_redirect=ex_pc_branch, id_flush=1, ex_bubble=1. Any load-use or jump this cycle is ignored (that instruction is squashed).
  3. Load-use: ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)) -> if_stall=id_stall=ex_bubble=1. id_jmp is not acted on this cycle; it is re-evaluated next cycle.
  4. Jump: id_jmp -> if_jmp=1, if_pc_redirect=id_pc_jmp, id_flush=1. ex_bubble=0, so the jump itself proceeds.
  5. Otherwise all controls 0.
- A mem_req with mem_ready=1 in the same cycle is a single-cycle access: no stall, priorities 2-5 apply.
- MEM_WAIT: if_stall=id_stall=mem_stall=1; branch, load-use and jump are all suppressed.
  - If mem_ready=1: stalls still asserted this cycle; next state RUN, counter=0.
  - Else, if counter==MEM_TIMEOUT: next state ERROR.
  - Else counter+1.
- ERROR: if_stall=id_stall=mem_stall=1 and mem_timeout=1 every cycle. Exit only via reset.
- stall_cycles increments when if_stall=1 and saturates at 16'hFFFF.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN the next cycle; any pending access is abandoned.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle if_stall=id_stall=ex_bubble=1, stall_cycles=1. Same with ex_rd=0 -> no stall.
- Branch vs jump: ex_branch=1, ex_alu_zero=1, ex_pc_branch=8'h40, id_jmp=1, id_pc_jmp=8'h80 -> if_jmp=1, if_pc_redirect=8'h40, id_flush=1, ex_bubble=1. With ex_alu_zero=0 -> redirect=8'h80, ex_bubble=0.
- Mem wait: mem_req=1, mem_ready low for 3 cycles then high -> mem_stall=1 for 4 cycles, then RUN, stall_cycles=4. A pending jump is taken the cycle after mem_ready.
- Watchdog: mem_req=1, mem_ready held 0 -> mem_timeout=1 after 1+MEM_TIMEOUT+1 cycles (17 at default) and stays set. Asserting reset clears it next cycle.
- Single-cycle access: mem_req=1, mem_ready=1 with a coincident load-use -> no mem_stall, load-use stall only.
- Saturation: hold load-use for 70000 cycles -> stall_cycles=16'hFFFF with no wrap.
